// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract: drives one external SLICE-bit adder one slice per cycle, LS slice first.
// Latency: result valid SLICES+1 cycles after accept (SLICES run cycles, then DONE); SLICES+2 cycles per op.
// Backpressure: in_ready only in IDLE; result and flags held in DONE until out_ready.
module cla_mp_sequencer #(
    parameter int SLICE  = 32,
    parameter int SLICES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE*SLICES-1:0]   in_a,
    input  logic [SLICE*SLICES-1:0]   in_b,
    input  logic                      in_sub,
    input  logic                      in_cin,
    output logic [SLICE-1:0]          add_a,
    output logic [SLICE-1:0]          add_b,
    output logic                      add_cin,
    input  logic [SLICE-1:0]          add_sum,
    input  logic                      add_cout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE*SLICES-1:0]   out_sum,
    output logic                      out_cout,
    output logic                      out_overflow
);

    localparam int W  = SLICE * SLICES;
    localparam int IW = $clog2(SLICES);
    localparam logic [IW-1:0] LAST_IDX = IW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            carry_r;
    logic            ovf_r;
    logic            last_slice;

    assign last_slice = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = a_r[int'(idx_q) * SLICE +: SLICE];
                add_b   = b_r[int'(idx_q) * SLICE +: SLICE];
                add_cin = carry_r;
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Subtract is folded into the operands: B is inverted once at accept and carry_r seeds the +1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_sub ? ~in_b : in_b;
                        carry_r <= in_sub ? 1'b1 : in_cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_r[int'(idx_q) * SLICE +: SLICE] <= add_sum;
                    carry_r <= add_cout;
                    if (last_slice) begin
                        idx_q <= '0;
                        // Top sum bit comes straight off the adder: sum_r is not yet updated this cycle.
                        ovf_r <= ~(a_r[W-1] ^ b_r[W-1]) & (a_r[W-1] ^ add_sum[SLICE-1]);
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum      = sum_r;
    assign out_cout     = carry_r;
    assign out_overflow = ovf_r;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Bench for cla_mp_sequencer: behavioural adder on the adder pins, arithmetic reference model,
// directed corner cases plus randomized operations with random sink stalls.
module tb_cla_mp_sequencer;

    localparam int SLICE  = 32;
    localparam int SLICES = 4;
    localparam int W      = SLICE * SLICES;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_sub;
    logic             in_cin;
    logic [SLICE-1:0] add_a;
    logic [SLICE-1:0] add_b;
    logic             add_cin;
    logic [SLICE-1:0] add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_cout;
    logic             out_overflow;

    int n_tests;
    int n_fail;

    cla_mp_sequencer #(.SLICE(SLICE), .SLICES(SLICES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .in_cin       (in_cin),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_cout     (out_cout),
        .out_overflow (out_overflow)
    );

    // External combinational adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{SLICE{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-width arithmetic, overflow from a sign-extended result.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  input logic cin, output logic [W-1:0] sum, output logic cout,
                                  output logic ovf);
        logic [W:0]   full;
        logic [W+1:0] ext;
        logic [W+1:0] sa;
        logic [W+1:0] sb;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        if (sub) begin
            sum  = a - b;
            cout = (a >= b);
            ext  = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            sum  = full[W-1:0];
            cout = full[W];
            ext  = sa + sb + {{(W+1){1'b0}}, cin};
        end
        ovf = ext[W] ^ ext[W-1];
    endfunction

    // Carry expected into slice k: carry out of the low k slices of the effective operation.
    function automatic logic slice_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub, input logic cin, input int k);
        logic [W:0] one;
        logic [W:0] mask;
        logic [W:0] lo;
        logic [W-1:0] beff;
        logic c0;
        c0   = sub ? 1'b1 : cin;
        beff = sub ? ~b : b;
        if (k == 0) return c0;
        one  = 1;
        mask = (one << (SLICE * k)) - 1;
        lo   = ({1'b0, a} & mask) + ({1'b0, beff} & mask) + {{W{1'b0}}, c0};
        return lo[SLICE * k];
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < SLICES; i++) begin
            case ($urandom_range(0, 3))
                0: v[i*SLICE +: SLICE] = '0;
                1: v[i*SLICE +: SLICE] = '1;
                default: v[i*SLICE +: SLICE] = $urandom;
            endcase
        end
        return v;
    endfunction

    // One operation: accept, per-slice adder pin checks, latency, hold in DONE, handshake.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input int hold, input bit noisy);
        logic [W-1:0] e_sum;
        logic e_cout;
        logic e_ovf;
        logic [W-1:0] beff;
        model(a, b, sub, cin, e_sum, e_cout, e_ovf);
        beff = sub ? ~b : b;
        chk({tag, ":in_ready_idle"}, {{W{1'b0}}, in_ready}, 1);
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = rand_word(); in_b = rand_word(); in_sub = $urandom; in_cin = $urandom;
        for (int k = 0; k < SLICES; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("%s:add_a[%0d]", tag, k), {1'b0, {(W-SLICE){1'b0}}, add_a},
                {1'b0, {(W-SLICE){1'b0}}, a[k*SLICE +: SLICE]});
            chk($sformatf("%s:add_b[%0d]", tag, k), {1'b0, {(W-SLICE){1'b0}}, add_b},
                {1'b0, {(W-SLICE){1'b0}}, beff[k*SLICE +: SLICE]});
            chk($sformatf("%s:add_cin[%0d]", tag, k), {{W{1'b0}}, add_cin},
                {{W{1'b0}}, slice_cin(a, b, sub, cin, k)});
            chk($sformatf("%s:busy[%0d]", tag, k), {{(W-1){1'b0}}, in_ready, out_valid}, 0);
        end
        @(negedge clk);
        chk({tag, ":out_valid_latency"}, {{W{1'b0}}, out_valid}, 1);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                if (noisy) begin
                    in_valid = ~in_valid;
                    in_a = rand_word(); in_b = rand_word(); in_sub = $urandom; in_cin = $urandom;
                end
                @(negedge clk);
            end
            chk({tag, ":out_sum"}, {1'b0, out_sum}, {1'b0, e_sum});
            chk({tag, ":flags"}, {{(W-2){1'b0}}, out_valid, out_cout, out_overflow},
                {{(W-2){1'b0}}, 1'b1, e_cout, e_ovf});
            chk({tag, ":in_ready_done"}, {{W{1'b0}}, in_ready}, 0);
            chk({tag, ":add_idle"}, {add_cin, add_a, add_b, {(W-2*SLICE){1'b0}}}, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":post_handshake"}, {{(W-1){1'b0}}, in_ready, out_valid}, 2);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out", {out_sum, out_cout}, 0);
        chk("reset_flags", {{(W-2){1'b0}}, out_valid, out_overflow, in_ready}, 1);
        chk("reset_add", {add_cin, add_a, add_b, {(W-2*SLICE){1'b0}}}, 0);

        run_op("carry_all", '1, 1, 1'b0, 1'b0, 0, 1'b0);
        a = '0; a[W-1] = 1'b0; a[W-2:0] = '1;
        run_op("signed_ovf", a, 1, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub_borrow", 5, 7, 1'b1, 1'b0, 0, 1'b0);
        run_op("slice_carry", 128'hFFFF_FFFF, 1, 1'b0, 1'b0, 0, 1'b0);
        run_op("backpressure", rand_word(), rand_word(), 1'b1, 1'b1, 10, 1'b1);
        run_op("after_bp", 128'd1234, 128'd99, 1'b0, 1'b1, 0, 1'b0);

        // Reset in the middle of a run, with slice 2 on the adder
        in_a = 3; in_b = 4; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out", {out_sum, out_cout}, 0);
        chk("midrun_rst_flags", {{(W-2){1'b0}}, out_valid, out_overflow}, 0);
        chk("midrun_rst_add", {add_cin, add_a, add_b, {(W-2*SLICE){1'b0}}}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < SLICES + 2; i++) begin
            @(negedge clk);
            chk("midrun_no_valid", {{W{1'b0}}, out_valid}, 0);
        end
        run_op("after_rst", 3, 4, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), rand_word(), rand_word(), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
